// File: rtl/ppx_sequencer_pkg.sv
// Shared definitions for the pulse-rate sequencer: state encoding,
// table field widths, the packed table entry and effective-parameter helpers.
package ppx_sequencer_pkg;

    localparam int unsigned XC_W   = 32;
    localparam int unsigned DUTY_W = 5;
    localparam int unsigned REPS_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } ppx_state_t;

    typedef struct packed {
        logic [XC_W-1:0]   xcount;
        logic [DUTY_W-1:0] duty_log2;
        logic [REPS_W-1:0] reps;
    } ppx_entry_t;

    // A zero period means "one second" at the system clock rate.
    function automatic logic [XC_W-1:0] eff_xc(input logic [XC_W-1:0] xcount,
                                               input logic [XC_W-1:0] clk_freq);
        return (xcount == '0) ? clk_freq : xcount;
    endfunction

    // A zero repeat count still spends one period in the entry.
    function automatic logic [REPS_W-1:0] eff_reps(input logic [REPS_W-1:0] reps);
        return (reps == '0) ? REPS_W'(1) : reps;
    endfunction

endpackage

// File: rtl/ppx_sequencer_if.sv
// Configuration, control and status bundle of the pulse-rate sequencer.
interface ppx_sequencer_if #(
    parameter int unsigned AW = 3
);
    import ppx_sequencer_pkg::*;

    logic                cfg_we;
    logic [AW-1:0]       cfg_addr;
    logic [XC_W-1:0]     cfg_xcount;
    logic [DUTY_W-1:0]   cfg_duty_log2;
    logic [REPS_W-1:0]   cfg_reps;
    logic [AW:0]         num_entries;
    logic                loop;
    logic                start;
    logic                stop;
    logic                busy;
    logic                done;
    logic                cfg_err;
    logic [AW-1:0]       cur_entry;
    logic                period_strobe;
    logic                ppx_out;

    modport master (
        output cfg_we, cfg_addr, cfg_xcount, cfg_duty_log2, cfg_reps,
        output num_entries, loop, start, stop,
        input  busy, done, cfg_err, cur_entry, period_strobe, ppx_out
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_xcount, cfg_duty_log2, cfg_reps,
        input  num_entries, loop, start, stop,
        output busy, done, cfg_err, cur_entry, period_strobe, ppx_out
    );

endinterface

// File: rtl/ppx_sequencer_sched_table.sv
// Pulse configuration register file: one write port, one asynchronous read port.
module ppx_sched_table
    import ppx_sequencer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  ppx_entry_t    wdata,
    input  logic [AW-1:0] raddr,
    output ppx_entry_t    rdata
);

    ppx_entry_t mem [DEPTH];

    // Table storage; reset clears every entry to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ppx_sequencer.sv
// Programmable pulse-rate sequencer: steps through a table of
// {period, duty, repeats} entries on period boundaries, without gap cycles.
module ppx_sequencer
    import ppx_sequencer_pkg::*;
#(
    parameter logic [31:0] CLK_FREQ = 32'd10_000_000,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AW       = 3
) (
    input  logic            clk,
    input  logic            reset,
    ppx_sequencer_if.slave  bus
);

    ppx_state_t        state, state_n;
    logic [AW-1:0]     entry, entry_n;
    logic [XC_W-1:0]   count, count_n;
    logic [XC_W-1:0]   xc, xc_n;
    logic [DUTY_W-1:0] duty, duty_n;
    logic [REPS_W-1:0] reps_left, reps_n;
    logic [AW:0]       num_q, num_n;
    logic              loop_q, loop_n;
    logic              done_q, done_n;
    logic              err_q, err_n;

    logic              pe;
    logic              last;
    logic              start_ok;
    logic              load;
    logic              finish;
    logic              tbl_we;
    logic [AW-1:0]     rd_addr;
    ppx_entry_t        rd_entry;
    ppx_entry_t        wr_entry;

    assign pe       = (count == xc - XC_W'(1));
    assign last     = (({1'b0, entry} + (AW+1)'(1)) == num_q);
    assign start_ok = (bus.num_entries != '0) && (bus.num_entries <= (AW+1)'(DEPTH));
    assign tbl_we   = bus.cfg_we && (state == ST_IDLE);
    // The read port always looks at the entry that would be loaded next,
    // so a new entry's parameters are latched on the same edge as the PE.
    assign rd_addr  = ((state == ST_IDLE) || last) ? '0 : entry + AW'(1);
    assign wr_entry = '{xcount: bus.cfg_xcount, duty_log2: bus.cfg_duty_log2, reps: bus.cfg_reps};

    ppx_sched_table #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_table (
        .clk   (clk),
        .reset (reset),
        .we    (tbl_we),
        .waddr (bus.cfg_addr),
        .wdata (wr_entry),
        .raddr (rd_addr),
        .rdata (rd_entry)
    );

    // Sequencer state, period/repeat counters and latched run parameters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            entry     <= '0;
            count     <= '0;
            xc        <= '0;
            duty      <= '0;
            reps_left <= '0;
            num_q     <= '0;
            loop_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_n;
            entry     <= entry_n;
            count     <= count_n;
            xc        <= xc_n;
            duty      <= duty_n;
            reps_left <= reps_n;
            num_q     <= num_n;
            loop_q    <= loop_n;
            done_q    <= done_n;
            err_q     <= err_n;
        end
    end

    // Next-state decode: start/stop handling, period end, entry advance.
    always_comb begin
        state_n = state;
        entry_n = entry;
        count_n = count;
        xc_n    = xc;
        duty_n  = duty;
        reps_n  = reps_left;
        num_n   = num_q;
        loop_n  = loop_q;
        done_n  = 1'b0;
        err_n   = 1'b0;
        load    = 1'b0;
        finish  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (start_ok) begin
                        state_n = ST_RUN;
                        entry_n = '0;
                        load    = 1'b1;
                        num_n   = bus.num_entries;
                        loop_n  = bus.loop;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                err_n   = bus.cfg_we;
                count_n = pe ? '0 : count + XC_W'(1);
                if (pe) begin
                    if (bus.stop) begin
                        finish = 1'b1;
                    end else if (reps_left > REPS_W'(1)) begin
                        reps_n = reps_left - REPS_W'(1);
                    end else if (!last) begin
                        entry_n = entry + AW'(1);
                        load    = 1'b1;
                    end else if (loop_q) begin
                        entry_n = '0;
                        load    = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end else if (bus.stop) begin
                    state_n = ST_STOPPING;
                end
            end
            ST_STOPPING: begin
                err_n   = bus.cfg_we;
                count_n = pe ? '0 : count + XC_W'(1);
                if (pe) begin
                    finish = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        if (load) begin
            xc_n    = eff_xc(rd_entry.xcount, CLK_FREQ);
            duty_n  = rd_entry.duty_log2;
            reps_n  = eff_reps(rd_entry.reps);
            count_n = '0;
        end

        if (finish) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
            entry_n = '0;
            count_n = '0;
        end
    end

    assign bus.busy          = (state != ST_IDLE);
    assign bus.done          = done_q;
    assign bus.cfg_err       = err_q;
    assign bus.cur_entry     = entry;
    assign bus.period_strobe = bus.busy && (count == '0);
    assign bus.ppx_out       = bus.busy &&
                               ((duty == '0) ? (count == '0) : (count < (xc >> duty)));

endmodule
